// File: rtl/wb_master_queued.sv
// Queued Wishbone classic master: buffers commands in a small FIFO and issues them
// one at a time with byte selects, ERR/RTY handling, bounded retries and a timeout.
module wb_master_queued #(
    parameter int unsigned data_wl     = 32,
    parameter int unsigned adr_wl      = 32,
    parameter int unsigned fifo_depth  = 4,
    parameter int unsigned timeout_cyc = 255,
    parameter int unsigned max_retry   = 3
) (
    input  logic                   clk,
    input  logic                   a_reset_h,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [data_wl/8-1:0]   wb_sel_o,
    output logic [adr_wl-1:0]      wb_adr_o,
    output logic [data_wl-1:0]     wb_dat_o,
    input  logic [data_wl-1:0]     wb_dat_i,
    input  logic                   start_i,
    input  logic [adr_wl-1:0]      addr_i,
    input  logic [data_wl-1:0]     data_i,
    input  logic [data_wl/8-1:0]   sel_i,
    input  logic                   we_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [1:0]             status_o,
    output logic [data_wl-1:0]     data_o
);

    localparam int unsigned SEL_W    = data_wl / 8;
    localparam int unsigned PTR_W    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned RTY_W    = (max_retry > 0) ? $clog2(max_retry + 1) : 1;
    localparam int unsigned TMO_W    = (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    localparam int unsigned TMO_LAST = (timeout_cyc == 0) ? 0 : timeout_cyc - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [1:0] STAT_OK  = 2'b00;
    localparam logic [1:0] STAT_ERR = 2'b01;
    localparam logic [1:0] STAT_RTY = 2'b10;
    localparam logic [1:0] STAT_TMO = 2'b11;

    // command storage
    logic [adr_wl-1:0]  fifo_adr [fifo_depth];
    logic [data_wl-1:0] fifo_dat [fifo_depth];
    logic [SEL_W-1:0]   fifo_sel [fifo_depth];
    logic               fifo_we  [fifo_depth];

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nx;
    logic               push, pop;

    logic [1:0]         state, state_nx;
    logic               cyc_nx, stb_nx, we_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic [adr_wl-1:0]  adr_nx;
    logic [data_wl-1:0] dat_nx;
    logic               valid_nx, busy_nx;
    logic [1:0]         status_nx;
    logic [data_wl-1:0] data_nx;
    logic [RTY_W-1:0]   rty_cnt, rty_nx;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nx;

    assign ready_o = (count != CNT_W'(fifo_depth));
    assign push    = start_i && ready_o;

    // FIFO payload write; storage needs no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_adr[wr_ptr] <= addr_i;
            fifo_dat[wr_ptr] <= data_i;
            fifo_sel[wr_ptr] <= sel_i;
            fifo_we[wr_ptr]  <= we_i;
        end
    end

    // next-state and output logic
    always_comb begin
        state_nx  = state;
        cyc_nx    = wb_cyc_o;
        stb_nx    = wb_stb_o;
        we_nx     = wb_we_o;
        sel_nx    = wb_sel_o;
        adr_nx    = wb_adr_o;
        dat_nx    = wb_dat_o;
        valid_nx  = 1'b0;
        status_nx = status_o;
        data_nx   = data_o;
        rty_nx    = rty_cnt;
        tmo_nx    = tmo_cnt;
        pop       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    adr_nx   = fifo_adr[rd_ptr];
                    dat_nx   = fifo_dat[rd_ptr];
                    sel_nx   = fifo_sel[rd_ptr];
                    we_nx    = fifo_we[rd_ptr];
                    cyc_nx   = 1'b1;
                    stb_nx   = 1'b1;
                    tmo_nx   = '0;
                    state_nx = ST_BUS;
                end
            end
            ST_BUS: begin
                tmo_nx = tmo_cnt + TMO_W'(1);
                if (wb_ack_i) begin
                    pop       = 1'b1;
                    valid_nx  = 1'b1;
                    status_nx = STAT_OK;
                    if (!wb_we_o) begin
                        data_nx = wb_dat_i;
                    end
                end else if (wb_err_i) begin
                    pop       = 1'b1;
                    valid_nx  = 1'b1;
                    status_nx = STAT_ERR;
                end else if (wb_rty_i) begin
                    if (rty_cnt < RTY_W'(max_retry)) begin
                        rty_nx   = rty_cnt + RTY_W'(1);
                        cyc_nx   = 1'b0;
                        stb_nx   = 1'b0;
                        state_nx = ST_GAP;
                    end else begin
                        pop       = 1'b1;
                        valid_nx  = 1'b1;
                        status_nx = STAT_RTY;
                    end
                end else if ((timeout_cyc != 0) && (tmo_cnt == TMO_W'(TMO_LAST))) begin
                    pop       = 1'b1;
                    valid_nx  = 1'b1;
                    status_nx = STAT_TMO;
                end
                if (pop) begin
                    cyc_nx   = 1'b0;
                    stb_nx   = 1'b0;
                    we_nx    = 1'b0;
                    rty_nx   = '0;
                    state_nx = ST_IDLE;
                end
            end
            ST_GAP: begin
                adr_nx   = fifo_adr[rd_ptr];
                dat_nx   = fifo_dat[rd_ptr];
                sel_nx   = fifo_sel[rd_ptr];
                we_nx    = fifo_we[rd_ptr];
                cyc_nx   = 1'b1;
                stb_nx   = 1'b1;
                tmo_nx   = '0;
                state_nx = ST_BUS;
            end
            default: begin
                cyc_nx   = 1'b0;
                stb_nx   = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase

        count_nx = count + CNT_W'(push) - CNT_W'(pop);
        busy_nx  = (count_nx != '0) || (state_nx != ST_IDLE);
    end

    // state, pointers and registered outputs
    always_ff @(posedge clk or posedge a_reset_h) begin
        if (a_reset_h) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rty_cnt  <= '0;
            tmo_cnt  <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            valid_o  <= 1'b0;
            status_o <= 2'b00;
            data_o   <= '0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nx;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nx;
            rty_cnt  <= rty_nx;
            tmo_cnt  <= tmo_nx;
            wb_cyc_o <= cyc_nx;
            wb_stb_o <= stb_nx;
            wb_we_o  <= we_nx;
            wb_sel_o <= sel_nx;
            wb_adr_o <= adr_nx;
            wb_dat_o <= dat_nx;
            valid_o  <= valid_nx;
            status_o <= status_nx;
            data_o   <= data_nx;
            busy_o   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_wb_master_queued.sv
// Directed bench for wb_master_queued: one instance with an 8-cycle timeout and
// a second with the timeout disabled.
module tb_wb_master_queued;

    logic        clk = 1'b0;
    logic        a_reset_h;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        start_i, we_i;
    logic [31:0] addr_i, data_i;
    logic [3:0]  sel_i;
    logic        ready_o, busy_o, valid_o;
    logic [1:0]  status_o;
    logic [31:0] data_o;

    logic        start1;
    logic        n_ack1 = 1'b0, n_err1 = 1'b0, n_rty1 = 1'b0;
    logic        cyc1, stb1, we1, ready1, busy1, valid1;
    logic [3:0]  sel1;
    logic [31:0] adr1, dat1, data1;
    logic [1:0]  status1;

    int checks = 0;
    int failures = 0;
    int vcnt = 0;

    always #5 clk = ~clk;

    wb_master_queued #(.data_wl(32), .adr_wl(32), .fifo_depth(4), .timeout_cyc(8), .max_retry(3)) dut (
        .clk(clk), .a_reset_h(a_reset_h),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .start_i(start_i), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .status_o(status_o), .data_o(data_o)
    );

    wb_master_queued #(.data_wl(32), .adr_wl(32), .fifo_depth(4), .timeout_cyc(0), .max_retry(3)) dut_nto (
        .clk(clk), .a_reset_h(a_reset_h),
        .wb_ack_i(n_ack1), .wb_err_i(n_err1), .wb_rty_i(n_rty1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_we_o(we1),
        .wb_sel_o(sel1), .wb_adr_o(adr1), .wb_dat_o(dat1), .wb_dat_i(wb_dat_i),
        .start_i(start1), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .ready_o(ready1), .busy_o(busy1), .valid_o(valid1), .status_o(status1), .data_o(data1)
    );

    always @(negedge clk) if (valid_o) vcnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        start_i = 1'b1; addr_i = a; data_i = d; sel_i = s; we_i = w;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_cyc(input string tag);
        int n = 0;
        while (!wb_cyc_o && n < 6) begin
            tick();
            n++;
        end
        chk(tag, 64'(wb_cyc_o), 64'd1);
    endtask

    initial begin
        int n;
        int v0;
        int hi;
        int vseen;
        logic [31:0] a;

        a_reset_h = 1'b1;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
        start_i = 0; start1 = 0; addr_i = '0; data_i = '0; sel_i = '0; we_i = 0;
        tick(); tick();
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_outs", 64'({wb_stb_o, wb_we_o, wb_sel_o, valid_o, status_o, busy_o}), 64'd0);
        chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'd0);
        chk("rst_data_o", 64'(data_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        a_reset_h = 1'b0;
        tick();

        // single read with two wait states
        push(32'h10, 32'h0, 4'hF, 1'b0);
        chk("rd_busy", 64'(busy_o), 64'd1);
        chk("rd_cyc_not_yet", 64'(wb_cyc_o), 64'd0);
        tick();
        chk("rd_issue", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'b1101111);
        chk("rd_adr", 64'(wb_adr_o), 64'h10);
        tick();
        chk("rd_cyc2", 64'(wb_cyc_o), 64'd1);
        tick();
        chk("rd_cyc3", 64'(wb_cyc_o), 64'd1);
        wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
        tick();
        wb_ack_i = 0;
        chk("rd_done_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rd_valid", 64'({valid_o, status_o}), 64'b100);
        chk("rd_data", 64'(data_o), 64'hDEADBEEF);
        tick();
        chk("rd_valid_pulse", 64'(valid_o), 64'd0);
        chk("rd_idle_busy", 64'(busy_o), 64'd0);
        chk("rd_vcnt", 64'(vcnt), 64'd1);

        // five back-to-back writes into a four-entry FIFO
        v0 = vcnt;
        start_i = 1;
        for (int i = 0; i < 5; i++) begin
            addr_i = 32'h100 + 32'(i * 4); data_i = 32'hA0 + 32'(i); sel_i = 4'hF; we_i = 1;
            tick();
            if (i == 3) chk("full_ready", 64'(ready_o), 64'd0);
        end
        start_i = 0;
        chk("full_ready_after5", 64'(ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wait_cyc("wr_issue");
            chk("wr_adr", 64'(wb_adr_o), 64'(32'h100 + 32'(i * 4)));
            chk("wr_dat_we", 64'({wb_we_o, wb_dat_o}), {31'd0, 1'b1, 32'hA0 + 32'(i)});
            wb_ack_i = 1;
            tick();
            wb_ack_i = 0;
            chk("wr_done", 64'({wb_cyc_o, valid_o, status_o}), 64'b0100);
        end
        tick(); tick(); tick();
        chk("wr_count4", 64'(vcnt - v0), 64'd4);
        chk("wr_fifth_dropped", 64'({wb_cyc_o, busy_o}), 64'd0);
        chk("wr_data_o_hold", 64'(data_o), 64'hDEADBEEF);

        // three retries then ack
        push(32'h40, 32'h0, 4'h3, 1'b0);
        wait_cyc("rty_issue");
        for (int r = 0; r < 3; r++) begin
            wb_rty_i = 1;
            tick();
            wb_rty_i = 0;
            chk("rty_gap", 64'({wb_cyc_o, wb_stb_o, valid_o}), 64'd0);
            tick();
            chk("rty_reissue", 64'({wb_cyc_o, wb_stb_o, wb_sel_o, wb_adr_o}), {26'd0, 1'b1, 1'b1, 4'h3, 32'h40});
        end
        wb_ack_i = 1; wb_dat_i = 32'h12345678;
        tick();
        wb_ack_i = 0;
        chk("rty_ok", 64'({wb_cyc_o, valid_o, status_o}), 64'b0100);
        chk("rty_ok_data", 64'(data_o), 64'h12345678);

        // four retries exhaust the budget
        push(32'h44, 32'h0, 4'hF, 1'b0);
        wait_cyc("rty4_issue");
        for (int r = 0; r < 3; r++) begin
            wb_rty_i = 1;
            tick();
            wb_rty_i = 0;
            tick();
        end
        chk("rty4_adr", 64'({wb_cyc_o, wb_adr_o}), {31'd0, 1'b1, 32'h44});
        wb_rty_i = 1; wb_dat_i = 32'h55555555;
        tick();
        wb_rty_i = 0;
        chk("rty4_fail", 64'({wb_cyc_o, valid_o, status_o}), 64'b0110);
        chk("rty4_data_hold", 64'(data_o), 64'h12345678);

        // error on a write, next command follows
        push(32'h20, 32'hA5A5A5A5, 4'hF, 1'b1);
        push(32'h30, 32'h0, 4'hF, 1'b0);
        wait_cyc("err_issue");
        chk("err_adr", 64'({wb_we_o, wb_adr_o}), {31'd0, 1'b1, 32'h20});
        wb_err_i = 1;
        tick();
        wb_err_i = 0;
        chk("err_status", 64'({wb_cyc_o, valid_o, status_o}), 64'b0101);
        chk("err_data_hold", 64'(data_o), 64'h12345678);
        wait_cyc("err_next_issue");
        chk("err_next_adr", 64'({wb_we_o, wb_adr_o}), {31'd0, 1'b0, 32'h30});
        wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D;
        tick();
        wb_ack_i = 0;
        chk("err_next_ok", 64'({valid_o, status_o, data_o}), {29'd0, 1'b1, 2'b00, 32'hCAFEF00D});

        // timeout after eight cycles of CYC
        push(32'h50, 32'h0, 4'hF, 1'b0);
        wait_cyc("tmo_issue");
        n = 0;
        while (wb_cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_len", 64'(n), 64'd8);
        chk("tmo_status", 64'({valid_o, status_o}), 64'b111);

        // timeout disabled: CYC holds indefinitely
        start1 = 1; addr_i = 32'h60; sel_i = 4'hF; we_i = 0;
        tick();
        start1 = 0;
        tick();
        hi = 0; vseen = 0;
        for (int i = 0; i < 300; i++) begin
            if (cyc1) hi++;
            if (valid1) vseen++;
            tick();
        end
        chk("nto_cyc_high", 64'(hi), 64'd300);
        chk("nto_no_valid", 64'(vseen), 64'd0);

        // reset in the middle of a bus cycle with entries queued
        v0 = vcnt;
        push(32'h70, 32'h1, 4'hF, 1'b1);
        push(32'h74, 32'h2, 4'hF, 1'b1);
        push(32'h78, 32'h3, 4'hF, 1'b1);
        chk("mid_cyc", 64'(wb_cyc_o), 64'd1);
        a_reset_h = 1;
        #1;
        chk("mid_rst_outs", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, valid_o, status_o, busy_o, cyc1}), 64'd0);
        chk("mid_rst_adr", 64'(wb_adr_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd1);
        tick();
        a_reset_h = 0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wb_cyc_o) hi++;
        end
        chk("post_rst_idle", 64'(hi), 64'd0);
        chk("post_rst_no_valid", 64'(vcnt - v0), 64'd0);
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
